// File: rtl/frame_scanout_pkg.sv
// Shared definitions for the frame buffer scan-out controller.
// Holds the read-strobe polarity and the controller state encoding
// so the top and any future companions agree on both.
package frame_scanout_pkg;

  // Frame buffer rd_en_in is active-low.
  localparam logic ASSERT   = 1'b0;
  localparam logic DEASSERT = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/frame_scanout_pix_skid_fifo.sv
// Purpose: 2-entry skid FIFO holding {last, pixel} between buffer read data and the pixel stream.
// Latency: push visible at head the clock after the push edge; head held while not popped.
// Backpressure: no internal full check; the caller's credit rule keeps pushes off a full FIFO.
// Ports: clk, reset (sync, active-high); push/push_dat write side; pop read side;
//        head = oldest entry (stale when count==0); count = occupancy 0..2.
module pix_skid_fifo
  import frame_scanout_pkg::*;
#(
  parameter int WIDTH = 25
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/frame_scanout.sv
// Purpose: drain one frame per request from the frame buffer and re-emit it as a valid/ready pixel stream.
// Latency: start sampled in cycle C -> strobe in C+1 -> pix_valid in C+3; P pixels end with frame_done in C+P+3.
// Backpressure: reads stall whenever the skid FIFO plus the in-flight read would exceed 2 entries.
// Ports: clk, reset (sync, active-high); start/buf_rdy request; fb_rd_en_n/rd_addr/fb_data buffer read port;
//        pix_data/pix_valid/pix_ready/pix_last output stream; busy and frame_done status.
module frame_scanout
  import frame_scanout_pkg::*;
#(
  parameter int DATA_WIDTH   = 24,
  parameter int ADDR_WIDTH   = 3,
  parameter int FRAME_PIXELS = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  buf_rdy,
  output logic                  fb_rd_en_n,
  input  logic [DATA_WIDTH-1:0] fb_data,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic                  pix_last,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = ADDR_WIDTH + 1;
  localparam logic [CW-1:0] FRAME_CNT = CW'(FRAME_PIXELS);
  localparam logic [CW-1:0] LAST_IDX  = CW'(FRAME_PIXELS - 1);

  state_t          state;
  logic [CW-1:0]   issued;
  logic            inflight;
  logic            inflight_last;
  logic [1:0]      fifo_count;
  logic [DATA_WIDTH:0] head;
  logic            pop;
  logic            strobe;
  logic [2:0]      occ_next;
  logic            credit_ok;

  pix_skid_fifo #(.WIDTH(DATA_WIDTH + 1)) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight),
    .push_dat ({inflight_last, fb_data}),
    .pop      (pop),
    .head     (head),
    .count    (fifo_count)
  );

  assign pix_valid = (fifo_count != 2'd0);
  assign pop       = pix_valid & pix_ready;
  assign pix_data  = head[DATA_WIDTH-1:0];
  assign pix_last  = pix_valid & head[DATA_WIDTH];

  // Occupancy once this cycle's pop leaves, plus the read already in flight.
  // Counting the pop lets a steady ready stream keep one read per clock.
  assign occ_next  = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
  assign credit_ok = (occ_next < 3'd2);

  assign strobe     = (state == ST_READ) && (issued < FRAME_CNT) && credit_ok;
  assign fb_rd_en_n = strobe ? ASSERT : DEASSERT;
  assign rd_addr    = issued[ADDR_WIDTH-1:0];

  assign busy       = (state == ST_READ) || (state == ST_DRAIN);
  assign frame_done = (state == ST_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      issued        <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      // Buffer data lands one clock after the strobe; tag the final pixel as it flies.
      inflight      <= strobe;
      inflight_last <= strobe && (issued == LAST_IDX);
      case (state)
        ST_IDLE: begin
          if (start && buf_rdy) begin
            state  <= ST_READ;
            issued <= '0;
          end
        end
        ST_READ: begin
          if (strobe) begin
            issued <= issued + 1'b1;
            if (issued == LAST_IDX) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (pop && head[DATA_WIDTH]) begin
            state <= ST_DONE;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_scanout.sv
module tb_frame_scanout;

  localparam int DW = 24;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          start      [2];
  logic          buf_rdy    [2];
  logic          pix_ready  [2];
  logic          fb_rd_en_n [2];
  logic          pix_valid  [2];
  logic          pix_last   [2];
  logic          busy       [2];
  logic          frame_done [2];
  logic [DW-1:0] fb_data    [2];
  logic [DW-1:0] pix_data   [2];
  logic [AW-1:0] rd_addr    [2];

  logic [DW-1:0] mem [8];

  frame_scanout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_PIXELS(8)) dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .buf_rdy(buf_rdy[0]),
    .fb_rd_en_n(fb_rd_en_n[0]), .fb_data(fb_data[0]), .rd_addr(rd_addr[0]),
    .pix_data(pix_data[0]), .pix_valid(pix_valid[0]), .pix_ready(pix_ready[0]),
    .pix_last(pix_last[0]), .busy(busy[0]), .frame_done(frame_done[0])
  );

  frame_scanout #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FRAME_PIXELS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .buf_rdy(buf_rdy[1]),
    .fb_rd_en_n(fb_rd_en_n[1]), .fb_data(fb_data[1]), .rd_addr(rd_addr[1]),
    .pix_data(pix_data[1]), .pix_valid(pix_valid[1]), .pix_ready(pix_ready[1]),
    .pix_last(pix_last[1]), .busy(busy[1]), .frame_done(frame_done[1])
  );

  // Frame buffer: registered read, one clock after the active-low strobe.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (fb_rd_en_n[d] === 1'b0) fb_data[d] <= mem[rd_addr[d]];
    end
  end

  int tests, fails, cyc;
  bit chk_en;
  // Transaction-level reference: reads issued, pixels accepted, frame status.
  int m_str [2];
  int m_acc [2];
  bit m_sd1 [2];
  bit m_busy[2];
  bit m_done[2];
  int start_cyc[2];
  int done_cyc [2];
  int obs_str  [2];
  int rmode    [2];
  int rp       [2];

  function automatic int pix_of(input int d);
    return (d == 0) ? 8 : 1;
  endfunction

  task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s[dut%0d] cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
    end
  endtask

  task automatic check_cycle(input int d);
    int  p, avail;
    bit  e_pop, e_strobe, was_done;
    p        = pix_of(d);
    avail    = m_str[d] - int'(m_sd1[d]) - m_acc[d];
    e_pop    = (avail > 0) && (pix_ready[d] === 1'b1);
    // At most two pixels may be read but not yet handed downstream after this cycle.
    e_strobe = m_busy[d] && (m_str[d] < p) && ((m_str[d] - m_acc[d] - int'(e_pop)) < 2);
    chk("busy", d, 32'(busy[d]), 32'(m_busy[d]));
    chk("frame_done", d, 32'(frame_done[d]), 32'(m_done[d]));
    chk("pix_valid", d, 32'(pix_valid[d]), 32'(avail > 0));
    chk("rd_en_n", d, 32'(fb_rd_en_n[d]), 32'(!e_strobe));
    if (e_strobe) chk("rd_addr", d, 32'(rd_addr[d]), 32'(m_str[d] % 8));
    if (avail > 0) begin
      chk("pix_data", d, 32'(pix_data[d]), 32'(mem[m_acc[d]]));
      chk("pix_last", d, 32'(pix_last[d]), 32'(m_acc[d] == p - 1));
    end
    if (fb_rd_en_n[d] === 1'b0) obs_str[d]++;
    if (frame_done[d] === 1'b1) done_cyc[d] = cyc;
    was_done = m_done[d];
    if (reset) begin
      m_str[d] = 0; m_acc[d] = 0; m_sd1[d] = 1'b0; m_busy[d] = 1'b0; m_done[d] = 1'b0;
    end else begin
      if (e_pop) m_acc[d]++;
      if (e_strobe) m_str[d]++;
      m_sd1[d]  = e_strobe;
      m_done[d] = 1'b0;
      if (m_busy[d] && e_pop && m_acc[d] == p) begin
        m_busy[d] = 1'b0;
        m_done[d] = 1'b1;
      end else if (!m_busy[d] && !was_done && start[d] && buf_rdy[d]) begin
        m_busy[d] = 1'b1; m_str[d] = 0; m_acc[d] = 0; m_sd1[d] = 1'b0;
        start_cyc[d] = cyc;
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (chk_en) for (int d = 0; d < 2; d++) check_cycle(d);
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      case (rmode[d])
        0:       pix_ready[d] = 1'b1;
        1:       pix_ready[d] = (rp[d] % 3 == 0);
        2:       pix_ready[d] = ($urandom_range(0, 3) != 0);
        default: pix_ready[d] = 1'b0;
      endcase
      rp[d]++;
    end
  endtask

  task automatic start_frame(input int d);
    start[d] = 1'b1; buf_rdy[d] = 1'b1;
    obs_str[d] = 0; done_cyc[d] = -1;
    step();
    start[d] = 1'b0;
  endtask

  task automatic run_frame(input int d, input int budget);
    int n;
    n = 0;
    while ((m_busy[d] || m_done[d]) && n < budget) begin
      step();
      n++;
    end
    chk("idle_after_frame", d, 32'(busy[d]), 32'd0);
    chk("no_done_after_frame", d, 32'(frame_done[d]), 32'd0);
  endtask

  task automatic reset_checks(input int d);
    chk("rst_rd_en_n", d, 32'(fb_rd_en_n[d]), 32'd1);
    chk("rst_rd_addr", d, 32'(rd_addr[d]), 32'd0);
    chk("rst_pix_valid", d, 32'(pix_valid[d]), 32'd0);
    chk("rst_pix_last", d, 32'(pix_last[d]), 32'd0);
    chk("rst_pix_data", d, 32'(pix_data[d]), 32'd0);
    chk("rst_busy", d, 32'(busy[d]), 32'd0);
    chk("rst_frame_done", d, 32'(frame_done[d]), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tests = 0; fails = 0; cyc = 0; chk_en = 1'b0;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      start[d] = 1'b0; buf_rdy[d] = 1'b0; pix_ready[d] = 1'b0;
      rmode[d] = 3; rp[d] = 0; m_str[d] = 0; m_acc[d] = 0; m_sd1[d] = 1'b0;
      m_busy[d] = 1'b0; m_done[d] = 1'b0; start_cyc[d] = 0; done_cyc[d] = -1; obs_str[d] = 0;
    end
    for (int i = 0; i < 8; i++) mem[i] = DW'(i * 3);
    @(posedge clk);
    #1;
    chk_en = 1'b1;
    step();
    reset_checks(0);
    reset_checks(1);
    reset = 1'b0;

    // Back-to-back frame, ready held high.
    rmode[0] = 0; pix_ready[0] = 1'b1;
    start_frame(0);
    run_frame(0, 100);
    chk("b2b_latency", 0, 32'(done_cyc[0] - start_cyc[0]), 32'd11);
    chk("b2b_strobes", 0, 32'(obs_str[0]), 32'd8);

    // Backpressure pattern 1,0,0 repeating.
    rmode[0] = 1; rp[0] = 0;
    start_frame(0);
    run_frame(0, 200);
    chk("bp_strobes", 0, 32'(obs_str[0]), 32'd8);

    // start without buf_rdy is not remembered.
    rmode[0] = 0; pix_ready[0] = 1'b1;
    start[0] = 1'b1; buf_rdy[0] = 1'b0;
    for (int i = 0; i < 5; i++) step();
    start[0] = 1'b0; buf_rdy[0] = 1'b1; obs_str[0] = 0;
    for (int i = 0; i < 3; i++) step();
    chk("no_req_busy", 0, 32'(busy[0]), 32'd0);
    chk("no_req_strobes", 0, 32'(obs_str[0]), 32'd0);
    start_frame(0);
    run_frame(0, 100);

    // Reset mid-frame while the 4th pixel waits on ready.
    start_frame(0);
    n = 0;
    while (m_acc[0] < 3 && n < 50) begin step(); n++; end
    rmode[0] = 3; pix_ready[0] = 1'b0;
    reset = 1'b1;
    step();
    reset = 1'b0;
    reset_checks(0);
    rmode[0] = 0; pix_ready[0] = 1'b1;
    start_frame(0);
    run_frame(0, 100);
    chk("post_rst_latency", 0, 32'(done_cyc[0] - start_cyc[0]), 32'd11);

    // Single-pixel frame with ready low for 3 clocks.
    rmode[1] = 3; pix_ready[1] = 1'b0;
    start_frame(1);
    n = 0;
    while (pix_valid[1] !== 1'b1 && n < 20) begin step(); n++; end
    for (int i = 0; i < 3; i++) begin
      chk("p1_hold_valid", 1, 32'(pix_valid[1]), 32'd1);
      chk("p1_hold_last", 1, 32'(pix_last[1]), 32'd1);
      step();
    end
    rmode[1] = 0; pix_ready[1] = 1'b1;
    run_frame(1, 50);
    chk("p1_strobes", 1, 32'(obs_str[1]), 32'd1);

    // Two frames, second started the clock after frame_done, random pixel data.
    for (int i = 0; i < 8; i++) mem[i] = DW'($urandom);
    start_frame(0);
    run_frame(0, 100);
    start_frame(0);
    run_frame(0, 100);
    chk("second_latency", 0, 32'(done_cyc[0] - start_cyc[0]), 32'd11);
    chk("second_strobes", 0, 32'(obs_str[0]), 32'd8);

    // Randomized frames on both instances with random ready and buf_rdy wiggle.
    rmode[0] = 2; rmode[1] = 2;
    for (int r = 0; r < 12; r++) begin
      for (int i = 0; i < 8; i++) mem[i] = DW'($urandom);
      n = $urandom_range(0, 3);
      for (int i = 0; i < n; i++) step();
      start[0] = 1'b1; start[1] = 1'b1; buf_rdy[0] = 1'b1; buf_rdy[1] = 1'b1;
      step();
      start[0] = 1'b0; start[1] = 1'b0;
      n = 0;
      while ((m_busy[0] || m_done[0] || m_busy[1] || m_done[1]) && n < 400) begin
        buf_rdy[0] = 1'($urandom_range(0, 1));
        buf_rdy[1] = 1'($urandom_range(0, 1));
        step();
        n++;
      end
      chk("rand_idle0", 0, 32'(busy[0]), 32'd0);
      chk("rand_idle1", 1, 32'(busy[1]), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
